// File: rtl/axi4lite_picoblaze_target_if.sv
// ---------------------------------------------------------------------------
// axi4lite_picoblaze_target_if
//   AXI4-Lite bus bundle between an external AXI master and the PicoBlaze
//   serviced target.
//
//   master modport : drives AW/W/AR requests and B/R ready, sees responses.
//   slave  modport : drives ready for AW/W/AR and the B/R responses.
//
//   Channels: AW (awaddr/awvalid/awready), W (wdata/wstrb/wvalid/wready),
//             B (bresp/bvalid/bready), AR (araddr/arvalid/arready),
//             R (rdata/rresp/rvalid/rready).
// ---------------------------------------------------------------------------
interface axi4lite_picoblaze_target_if #(
  parameter int C_ADDRESS_WIDTH = 32
);
  logic [C_ADDRESS_WIDTH-1:0] awaddr;
  logic                       awvalid;
  logic                       awready;
  logic [31:0]                wdata;
  logic [3:0]                 wstrb;
  logic                       wvalid;
  logic                       wready;
  logic [1:0]                 bresp;
  logic                       bvalid;
  logic                       bready;
  logic [C_ADDRESS_WIDTH-1:0] araddr;
  logic                       arvalid;
  logic                       arready;
  logic [31:0]                rdata;
  logic [1:0]                 rresp;
  logic                       rvalid;
  logic                       rready;

  modport master (
    output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/axi4lite_picoblaze_target.sv
// ---------------------------------------------------------------------------
// axi4lite_picoblaze_target
//   AXI4-Lite slave whose transactions are serviced by PicoBlaze firmware.
//   A captured AXI read or write raises irq; firmware inspects the captured
//   address/data/strobes through a 32-port window, supplies read data and a
//   response, then writes COMPLETE to release BVALID or RVALID.
//
//   Ports
//     s_axi_aclk     single clock for PicoBlaze and AXI sides
//     s_axi_aresetn  asynchronous active-low reset
//     port_id        PicoBlaze port id (window selected by port_id[7:5])
//     write_strobe   PicoBlaze write strobe
//     read_strobe    PicoBlaze read strobe (reads have no side effects)
//     out_port       PicoBlaze write data
//     in_port        PicoBlaze read data, combinational from port_id
//     irq            high while a captured transaction awaits firmware
//     s_axi          AXI4-Lite slave bundle
//
//   Port window (offset = port_id[4:0])
//     0x00-0x03  DATA[31:0] little endian, R/W (firmware writes ignored in RESP)
//     0x08-0x0B  ADDR[31:0] captured address, read-only
//     0x10       CONTROL  read {2'b0,resp,2'b0,wnr,pending}
//                         write bit2=COMPLETE, bits[5:4]=RESP
//     0x11       {4'b0,wstrb}, read-only
// ---------------------------------------------------------------------------
module axi4lite_picoblaze_target #(
  parameter int         C_ADDRESS_WIDTH = 32,
  parameter logic [7:0] C_BASE_ADDRESS  = 8'h20
) (
  input  logic       s_axi_aclk,
  input  logic       s_axi_aresetn,
  input  logic [7:0] port_id,
  input  logic       write_strobe,
  input  logic       read_strobe,
  input  logic [7:0] out_port,
  output logic [7:0] in_port,
  output logic       irq,
  axi4lite_picoblaze_target_if.slave s_axi
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PEND = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam logic [4:0] OFS_CONTROL = 5'h10;
  localparam logic [4:0] OFS_WSTRB   = 5'h11;

  state_t      state;
  logic        aw_got;
  logic        w_got;
  logic        wnr;
  logic [1:0]  resp;
  logic [31:0] data_q;
  logic [31:0] addr_q;
  logic [3:0]  wstrb_q;

  logic        awready_q;
  logic        wready_q;
  logic        ar_en_q;
  logic        bvalid_q;
  logic        rvalid_q;
  logic [1:0]  bresp_q;
  logic [1:0]  rresp_q;
  logic [31:0] rdata_q;
  logic        irq_q;

  logic        win_sel;
  logic        fw_data_wr;
  logic        fw_ctrl_wr;
  logic        aw_hs;
  logic        w_hs;
  logic        ar_hs;
  logic        aw_next;
  logic        w_next;
  logic        b_done;
  logic        r_done;
  logic [31:0] aw_ext;
  logic [31:0] ar_ext;

  // Reads have no side effects, so the read strobe is intentionally ignored.
  logic unused_read_strobe;
  assign unused_read_strobe = read_strobe;

  assign win_sel    = (port_id[7:5] == C_BASE_ADDRESS[7:5]);
  assign fw_data_wr = write_strobe && win_sel && (port_id[4:2] == 3'b000);
  assign fw_ctrl_wr = write_strobe && win_sel && (port_id[4:0] == OFS_CONTROL);

  // AR is only offered when no write has started and none is being offered,
  // so a write always wins a simultaneous arrival.
  assign s_axi.awready = awready_q;
  assign s_axi.wready  = wready_q;
  assign s_axi.arready = ar_en_q && !s_axi.awvalid && !s_axi.wvalid;
  assign s_axi.bvalid  = bvalid_q;
  assign s_axi.bresp   = bresp_q;
  assign s_axi.rvalid  = rvalid_q;
  assign s_axi.rresp   = rresp_q;
  assign s_axi.rdata   = rdata_q;
  assign irq           = irq_q;

  assign aw_hs   = s_axi.awvalid && awready_q;
  assign w_hs    = s_axi.wvalid && wready_q;
  assign ar_hs   = s_axi.arvalid && s_axi.arready;
  assign aw_next = aw_got || aw_hs;
  assign w_next  = w_got || w_hs;
  assign b_done  = bvalid_q && s_axi.bready;
  assign r_done  = rvalid_q && s_axi.rready;

  // Narrow AXI addresses are zero-extended so unused ADDR bits read back 0.
  always_comb begin
    aw_ext = '0;
    ar_ext = '0;
    aw_ext[C_ADDRESS_WIDTH-1:0] = s_axi.awaddr;
    ar_ext[C_ADDRESS_WIDTH-1:0] = s_axi.araddr;
  end

  // Transaction FSM: capture in IDLE, firmware service in PEND, AXI response in RESP.
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      state     <= ST_IDLE;
      aw_got    <= 1'b0;
      w_got     <= 1'b0;
      wnr       <= 1'b0;
      resp      <= 2'b00;
      data_q    <= '0;
      addr_q    <= '0;
      wstrb_q   <= '0;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      ar_en_q   <= 1'b0;
      bvalid_q  <= 1'b0;
      rvalid_q  <= 1'b0;
      bresp_q   <= 2'b00;
      rresp_q   <= 2'b00;
      rdata_q   <= '0;
      irq_q     <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (fw_data_wr) begin
            data_q[{port_id[1:0], 3'b000} +: 8] <= out_port;
          end
          // AXI write data takes precedence over a same-cycle firmware byte write.
          if (w_hs) begin
            data_q  <= s_axi.wdata;
            wstrb_q <= s_axi.wstrb;
            w_got   <= 1'b1;
          end
          if (aw_hs) begin
            addr_q <= aw_ext;
            aw_got <= 1'b1;
          end
          if (aw_next && w_next) begin
            wnr       <= 1'b1;
            state     <= ST_PEND;
            irq_q     <= 1'b1;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            ar_en_q   <= 1'b0;
          end else if (ar_hs) begin
            addr_q    <= ar_ext;
            wnr       <= 1'b0;
            state     <= ST_PEND;
            irq_q     <= 1'b1;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            ar_en_q   <= 1'b0;
          end else begin
            // Each of AW and W is accepted once; AR waits until neither has started.
            awready_q <= !aw_next;
            wready_q  <= !w_next;
            ar_en_q   <= !aw_next && !w_next;
          end
        end

        ST_PEND: begin
          if (fw_data_wr) begin
            data_q[{port_id[1:0], 3'b000} +: 8] <= out_port;
          end
          if (fw_ctrl_wr) begin
            resp <= out_port[5:4];
            if (out_port[2]) begin
              state <= ST_RESP;
              irq_q <= 1'b0;
              if (wnr) begin
                bvalid_q <= 1'b1;
                bresp_q  <= out_port[5:4];
              end else begin
                rvalid_q <= 1'b1;
                rresp_q  <= out_port[5:4];
                rdata_q  <= data_q;
              end
            end
          end
        end

        ST_RESP: begin
          // Readies stay low on the handshake edge; new requests open one cycle later.
          if (b_done || r_done) begin
            bvalid_q <= 1'b0;
            rvalid_q <= 1'b0;
            aw_got   <= 1'b0;
            w_got    <= 1'b0;
            state    <= ST_IDLE;
          end
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // Firmware read mux, combinational from port_id.
  always_comb begin
    in_port = 8'h00;
    if (win_sel) begin
      case (port_id[4:0])
        5'h00, 5'h01, 5'h02, 5'h03: in_port = data_q[{port_id[1:0], 3'b000} +: 8];
        5'h08, 5'h09, 5'h0A, 5'h0B: in_port = addr_q[{port_id[1:0], 3'b000} +: 8];
        OFS_CONTROL: in_port = {2'b00, resp, 2'b00, wnr, (state == ST_PEND)};
        OFS_WSTRB:   in_port = {4'b0000, wstrb_q};
        default:     in_port = 8'h00;
      endcase
    end
  end

endmodule

// File: tb/tb_axi4lite_picoblaze_target.sv
module tb_axi4lite_picoblaze_target;

  localparam int AW = 32;
  localparam logic [7:0] P_DATA = 8'h20;
  localparam logic [7:0] P_ADDR = 8'h28;
  localparam logic [7:0] P_CTRL = 8'h30;
  localparam logic [7:0] P_STRB = 8'h31;

  logic       clk;
  logic       rst_n;
  logic [7:0] port_id;
  logic       write_strobe;
  logic       read_strobe;
  logic [7:0] out_port;
  logic [7:0] in_port;
  logic       irq;

  axi4lite_picoblaze_target_if #(.C_ADDRESS_WIDTH(AW)) bus ();

  axi4lite_picoblaze_target #(
    .C_ADDRESS_WIDTH(AW),
    .C_BASE_ADDRESS (8'h20)
  ) dut (
    .s_axi_aclk   (clk),
    .s_axi_aresetn(rst_n),
    .port_id      (port_id),
    .write_strobe (write_strobe),
    .read_strobe  (read_strobe),
    .out_port     (out_port),
    .in_port      (in_port),
    .irq          (irq),
    .s_axi        (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic [1:0]  resp;
  } r_exp_t;

  typedef struct {
    logic [7:0] port;
    logic [7:0] val;
  } in_exp_t;

  logic [1:0] exp_b[$];
  r_exp_t     exp_r[$];
  in_exp_t    exp_in[$];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: compares whatever the DUT presents against queued expectations.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.bvalid && bus.bready) begin
        if (exp_b.size() == 0) chk("b_unexpected", 32'd1, 32'd0);
        else chk("bresp", {30'd0, bus.bresp}, {30'd0, exp_b.pop_front()});
      end
      if (bus.rvalid && bus.rready) begin
        if (exp_r.size() == 0) chk("r_unexpected", 32'd1, 32'd0);
        else begin
          r_exp_t e;
          e = exp_r.pop_front();
          chk("rdata", bus.rdata, e.data);
          chk("rresp", {30'd0, bus.rresp}, {30'd0, e.resp});
        end
      end
      if (read_strobe) begin
        if (exp_in.size() == 0) chk("in_port_unexpected", 32'd1, 32'd0);
        else begin
          in_exp_t e;
          e = exp_in.pop_front();
          chk($sformatf("in_port[%02h]", e.port), {24'd0, in_port}, {24'd0, e.val});
        end
      end
    end
  end

  task automatic align();
    @(posedge clk);
    #1;
  endtask

  task automatic fw_wr(input logic [7:0] p, input logic [7:0] d);
    align();
    port_id      = p;
    out_port     = d;
    write_strobe = 1'b1;
    align();
    write_strobe = 1'b0;
  endtask

  task automatic fw_rd(input logic [7:0] p, input logic [7:0] e);
    in_exp_t x;
    align();
    x.port = p;
    x.val  = e;
    exp_in.push_back(x);
    port_id     = p;
    read_strobe = 1'b1;
    align();
    read_strobe = 1'b0;
  endtask

  task automatic aw_send(input logic [31:0] a, input int lim);
    bit ok;
    ok = 0;
    align();
    bus.awaddr  = a;
    bus.awvalid = 1'b1;
    for (int i = 0; i < lim; i++) begin
      @(negedge clk);
      if (bus.awready) begin ok = 1; break; end
    end
    align();
    bus.awvalid = 1'b0;
    chk("aw_handshake", {31'd0, ok}, 32'd1);
  endtask

  task automatic w_send(input logic [31:0] d, input logic [3:0] s, input int lim);
    bit ok;
    ok = 0;
    align();
    bus.wdata  = d;
    bus.wstrb  = s;
    bus.wvalid = 1'b1;
    for (int i = 0; i < lim; i++) begin
      @(negedge clk);
      if (bus.wready) begin ok = 1; break; end
    end
    align();
    bus.wvalid = 1'b0;
    chk("w_handshake", {31'd0, ok}, 32'd1);
  endtask

  task automatic ar_send(input logic [31:0] a, input int lim);
    bit ok;
    ok = 0;
    align();
    bus.araddr  = a;
    bus.arvalid = 1'b1;
    for (int i = 0; i < lim; i++) begin
      @(negedge clk);
      if (bus.arready) begin ok = 1; break; end
    end
    align();
    bus.arvalid = 1'b0;
    chk("ar_handshake", {31'd0, ok}, 32'd1);
  endtask

  task automatic wait_irq(input string name);
    bit ok;
    ok = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (irq) begin ok = 1; break; end
    end
    chk(name, {31'd0, ok}, 32'd1);
  endtask

  task automatic pulse_bready();
    bus.bready = 1'b1;
    align();
    bus.bready = 1'b0;
  endtask

  task automatic chk_all_low(input string tag);
    chk({tag, "_irq"},     {31'd0, irq},         32'd0);
    chk({tag, "_awready"}, {31'd0, bus.awready}, 32'd0);
    chk({tag, "_wready"},  {31'd0, bus.wready},  32'd0);
    chk({tag, "_arready"}, {31'd0, bus.arready}, 32'd0);
    chk({tag, "_bvalid"},  {31'd0, bus.bvalid},  32'd0);
    chk({tag, "_rvalid"},  {31'd0, bus.rvalid},  32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    port_id = 8'h00; write_strobe = 1'b0; read_strobe = 1'b0; out_port = 8'h00;
    bus.awaddr = '0; bus.awvalid = 1'b0;
    bus.wdata = '0; bus.wstrb = '0; bus.wvalid = 1'b0;
    bus.bready = 1'b0;
    bus.araddr = '0; bus.arvalid = 1'b0;
    bus.rready = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    port_id = P_DATA;
    #1;
    chk_all_low("reset");
    chk("reset_bresp", {30'd0, bus.bresp}, 32'd0);
    chk("reset_rresp", {30'd0, bus.rresp}, 32'd0);
    chk("reset_data", {24'd0, in_port}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // 1: AW+W same cycle
    fork
      aw_send(32'h40, 20);
      w_send(32'hDEADBEEF, 4'hF, 20);
    join
    @(negedge clk);
    chk("t1_irq_next_cycle", {31'd0, irq}, 32'd1);
    chk("t1_ready_low_pend", {30'd0, bus.awready, bus.wready}, 32'd0);
    fw_rd(P_ADDR + 8'd0, 8'h40);
    fw_rd(P_ADDR + 8'd1, 8'h00);
    fw_rd(P_ADDR + 8'd2, 8'h00);
    fw_rd(P_ADDR + 8'd3, 8'h00);
    fw_rd(P_DATA + 8'd0, 8'hEF);
    fw_rd(P_DATA + 8'd1, 8'hBE);
    fw_rd(P_DATA + 8'd2, 8'hAD);
    fw_rd(P_DATA + 8'd3, 8'hDE);
    fw_rd(P_CTRL, 8'h03);
    fw_rd(P_STRB, 8'h0F);
    exp_b.push_back(2'b00);
    fw_wr(P_CTRL, 8'h04);
    @(negedge clk);
    chk("t1_bvalid", {31'd0, bus.bvalid}, 32'd1);
    chk("t1_bresp", {30'd0, bus.bresp}, 32'd0);
    chk("t1_irq_cleared", {31'd0, irq}, 32'd0);
    align();
    pulse_bready();
    @(negedge clk);
    chk("t1_bvalid_dropped", {31'd0, bus.bvalid}, 32'd0);

    // 2: read with held rready
    ar_send(32'h1234, 20);
    wait_irq("t2_irq");
    fw_rd(P_CTRL, 8'h01);
    fw_rd(P_ADDR + 8'd0, 8'h34);
    fw_rd(P_ADDR + 8'd1, 8'h12);
    fw_rd(P_ADDR + 8'd2, 8'h00);
    fw_rd(P_ADDR + 8'd3, 8'h00);
    fw_wr(P_DATA + 8'd0, 8'hFF);
    fw_wr(P_DATA + 8'd1, 8'h00);
    fw_wr(P_DATA + 8'd2, 8'hAA);
    fw_wr(P_DATA + 8'd3, 8'h55);
    exp_r.push_back('{data: 32'h55AA00FF, resp: 2'b10});
    fw_wr(P_CTRL, 8'h24);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t2_rvalid_hold", {31'd0, bus.rvalid}, 32'd1);
      chk("t2_rdata_hold", bus.rdata, 32'h55AA00FF);
      chk("t2_rresp_hold", {30'd0, bus.rresp}, 32'd2);
    end
    // 6b: firmware DATA write while in RESP is ignored
    fw_wr(P_DATA + 8'd0, 8'h11);
    fw_rd(P_DATA + 8'd0, 8'hFF);
    @(negedge clk);
    chk("t6_rdata_unchanged", bus.rdata, 32'h55AA00FF);
    chk("t6_rvalid_still", {31'd0, bus.rvalid}, 32'd1);
    align();
    bus.rready = 1'b1;
    align();
    bus.rready = 1'b0;
    @(negedge clk);
    chk("t2_rvalid_dropped", {31'd0, bus.rvalid}, 32'd0);
    fw_rd(P_CTRL, 8'h20);

    // 3: W three cycles before AW
    w_send(32'hCAFEF00D, 4'h5, 20);
    @(negedge clk);
    chk("t3_wready_dropped", {31'd0, bus.wready}, 32'd0);
    chk("t3_awready_open", {31'd0, bus.awready}, 32'd1);
    chk("t3_no_irq", {31'd0, irq}, 32'd0);
    repeat (2) begin
      @(negedge clk);
      chk("t3_no_irq_wait", {31'd0, irq}, 32'd0);
    end
    aw_send(32'h80, 20);
    @(negedge clk);
    chk("t3_irq", {31'd0, irq}, 32'd1);
    fw_rd(P_STRB, 8'h05);
    fw_rd(P_DATA + 8'd0, 8'h0D);
    fw_rd(P_DATA + 8'd1, 8'hF0);
    fw_rd(P_DATA + 8'd2, 8'hFE);
    fw_rd(P_DATA + 8'd3, 8'hCA);
    fw_rd(P_ADDR + 8'd0, 8'h80);
    fw_rd(P_ADDR + 8'd1, 8'h00);
    fw_rd(P_CTRL, 8'h23);
    exp_b.push_back(2'b01);
    fw_wr(P_CTRL, 8'h14);
    pulse_bready();

    // 4: AR collides with AW+W; write served first
    fork
      aw_send(32'hA0, 20);
      w_send(32'h0BADCAFE, 4'hC, 20);
      ar_send(32'hB4, 300);
    join_none
    wait_irq("t4_irq_write");
    chk("t4_arready_blocked", {31'd0, bus.arready}, 32'd0);
    fw_rd(P_CTRL, 8'h13);
    fw_rd(P_ADDR + 8'd0, 8'hA0);
    fw_rd(P_STRB, 8'h0C);
    bus.bready = 1'b1;
    exp_b.push_back(2'b00);
    fw_wr(P_CTRL, 8'h04);
    align();
    align();
    bus.bready = 1'b0;
    wait_irq("t4_irq_read");
    fw_rd(P_CTRL, 8'h01);
    fw_rd(P_ADDR + 8'd0, 8'hB4);
    fw_wr(P_DATA + 8'd0, 8'h04);
    fw_wr(P_DATA + 8'd1, 8'h03);
    fw_wr(P_DATA + 8'd2, 8'h02);
    fw_wr(P_DATA + 8'd3, 8'h01);
    bus.rready = 1'b1;
    exp_r.push_back('{data: 32'h01020304, resp: 2'b11});
    fw_wr(P_CTRL, 8'h34);
    align();
    align();
    bus.rready = 1'b0;
    wait fork;

    // 6a: COMPLETE in IDLE does nothing
    fw_wr(P_CTRL, 8'h04);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t6_idle_bvalid", {31'd0, bus.bvalid}, 32'd0);
      chk("t6_idle_rvalid", {31'd0, bus.rvalid}, 32'd0);
      chk("t6_idle_irq", {31'd0, irq}, 32'd0);
    end

    // 5: reset in PEND, then in RESP
    fork
      aw_send(32'h60, 20);
      w_send(32'h0BADF00D, 4'hF, 20);
    join
    wait_irq("t5_irq_pend");
    #2 rst_n = 1'b0;
    #1 chk_all_low("t5_rst_pend");
    @(negedge clk);
    rst_n = 1'b1;
    fw_rd(P_DATA + 8'd0, 8'h00);
    fw_rd(P_ADDR + 8'd0, 8'h00);
    fw_rd(P_CTRL, 8'h00);
    fw_rd(P_STRB, 8'h00);

    fork
      aw_send(32'h64, 20);
      w_send(32'h00000001, 4'h1, 20);
    join
    wait_irq("t5_irq_resp");
    fw_wr(P_CTRL, 8'h04);
    @(negedge clk);
    chk("t5_bvalid_before_rst", {31'd0, bus.bvalid}, 32'd1);
    #2 rst_n = 1'b0;
    #1 chk_all_low("t5_rst_resp");
    chk("t5_rst_bresp", {30'd0, bus.bresp}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    fork
      aw_send(32'h44, 20);
      w_send(32'h12345678, 4'h3, 20);
    join
    wait_irq("t5_irq_after");
    fw_rd(P_DATA + 8'd0, 8'h78);
    fw_rd(P_STRB, 8'h03);
    fw_rd(P_ADDR + 8'd0, 8'h44);
    exp_b.push_back(2'b00);
    fw_wr(P_CTRL, 8'h04);
    pulse_bready();

    repeat (3) align();
    chk("b_queue_drained", exp_b.size(), 32'd0);
    chk("r_queue_drained", exp_r.size(), 32'd0);
    chk("in_queue_drained", exp_in.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
